// File: rtl/mdu_unit_pkg.sv
// Shared E-stage opcode encodings (ALU and MDU) plus small helpers for the multiply/divide unit.
package mdu_unit_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_LUI  = 4'd7;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Counter wide enough to hold n, never narrower than 4 bits.
  function automatic int cnt_width(input int n);
    int w;
    w = 4;
    while ((1 << w) <= n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational mult/multu/div/divu producing {hi,lo} and a divide-by-zero flag.
// Zero latency, no flow control; the caller samples it on the Start edge.
module mdu_calc
  import mdu_unit_pkg::*;
(
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic [3:0]  op,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dz
);

  logic        is_signed;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    ext_a     = {{32{is_signed & srca[31]}}, srca};
    ext_b     = {{32{is_signed & srcb[31]}}, srcb};
    prod      = ext_a * ext_b;

    // Divide on magnitudes so the signed overflow case (-2^31 / -1) stays well defined.
    mag_a = (is_signed && srca[31]) ? -srca : srca;
    mag_b = (is_signed && srcb[31]) ? -srcb : srcb;
    quo   = (mag_b == '0) ? '0 : mag_a / mag_b;
    rem   = (mag_b == '0) ? '0 : mag_a % mag_b;

    dz = ((op == MDU_DIV) || (op == MDU_DIVU)) && (srcb == '0);
    hi = '0;
    lo = '0;
    case (op)
      MDU_MULT, MDU_MULTU: {hi, lo} = prod;
      MDU_DIV, MDU_DIVU: begin
        lo = (is_signed && (srca[31] ^ srcb[31])) ? -quo : quo;
        hi = (is_signed && srca[31]) ? -rem : rem;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: result held in shadow regs, committed to HI/LO after N busy cycles.
// Start/MTHI/MTLO are dropped while Busy; hazard control stalls them. Result is combinational.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] Result
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = cnt_width(MAXC);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   hi, lo, hi_n, lo_n;
  logic [31:0]   calc_hi, calc_lo;
  logic          calc_dz;

  mdu_calc u_calc (
    .srca (SrcA),
    .srcb (SrcB),
    .op   (MDUOp),
    .hi   (calc_hi),
    .lo   (calc_lo),
    .dz   (calc_dz)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      hi_n  <= '0;
      lo_n  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start && is_muldiv(MDUOp)) begin
            // Divide by zero re-commits the current HI/LO, leaving them unchanged.
            hi_n  <= calc_dz ? hi : calc_hi;
            lo_n  <= calc_dz ? lo : calc_lo;
            cnt   <= ((MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU)) ? MULT_LD : DIV_LD;
            state <= S_RUN;
          end else if (MDUOp == MDU_MTHI) begin
            hi <= SrcA;
          end else if (MDUOp == MDU_MTLO) begin
            lo <= SrcA;
          end
        end
        S_RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            hi    <= hi_n;
            lo    <= lo_n;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Busy = (state == S_RUN);

  always_comb begin
    Result = '0;
    if (MDUOp == MDU_MFHI)      Result = hi;
    else if (MDUOp == MDU_MFLO) Result = lo;
  end

endmodule
